// File: rtl/ps2_key_tracker_if.sv
// Bus between the PS/2 pins, the key tracker and the game FSM's key lookup.
//   ps2_clk, ps2_data : raw PS/2 pins (asynchronous to clk)
//   key_down[127:0]   : bit c high while the key with scan code c is held
//   last_change[6:0]  : code of the most recent accepted make/break
//   key_valid         : one-cycle pulse when key_down/last_change update
//   frame_err         : one-cycle pulse on parity, stop-bit or timeout error
// The master modport is the tracker. The slave modport is the pin driver and
// output consumer.
interface ps2_key_tracker_if;
  logic         ps2_clk;
  logic         ps2_data;
  logic [127:0] key_down;
  logic [6:0]   last_change;
  logic         key_valid;
  logic         frame_err;

  modport master (input ps2_clk, ps2_data,
                  output key_down, last_change, key_valid, frame_err);
  modport slave  (output ps2_clk, ps2_data,
                  input key_down, last_change, key_valid, frame_err);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver and scan-code set 2 key tracker.
// The block synchronizes the pins and receives 11-bit frames (start, 8 data
// LSB first, odd parity, stop). It then decodes make/break sequences into a
// pressed-key bitmap.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : ps2_key_tracker_if.master (pins in; key_down, last_change,
//              key_valid, frame_err out)
// Latency: the stop-bit edge_det at cycle T gives byte_strobe/frame_err at
// T+1 and key_valid at T+2.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input logic             clk,
  input logic             rst,
  ps2_key_tracker_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronizers reset to 1 (idle bus level), so reset never creates a
  // spurious falling edge.
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end

  logic edge_det, bit_in;
  assign edge_det = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in   = data_sync[SYNC_STAGES-1];

  // Frame receiver
  logic [3:0]    bit_idx;
  logic [7:0]    shreg, rx_byte;
  logic          par_bit, byte_strobe, rx_err;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_idx     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      par_bit     <= 1'b0;
      byte_strobe <= 1'b0;
      rx_err      <= 1'b0;
      to_cnt      <= '0;
    end else begin
      byte_strobe <= 1'b0;
      rx_err      <= 1'b0;
      if (edge_det) begin
        to_cnt <= '0;
        case (bit_idx)
          4'd0:  if (!bit_in) bit_idx <= 4'd1;  // a high start bit is line noise
          4'd9:  begin par_bit <= bit_in; bit_idx <= 4'd10; end
          4'd10: begin
            bit_idx <= 4'd0;
            // Odd parity means the 9 bits (data + parity) have odd weight.
            if ((^{shreg, par_bit}) && bit_in) begin
              byte_strobe <= 1'b1;
              rx_byte     <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_idx <= bit_idx + 4'd1;
          end
        endcase
      end else if (bit_idx != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_idx <= 4'd0;
          to_cnt  <= '0;
          rx_err  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end

  // Make/break decoder
  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;
  state_t state, state_n;
  logic   do_make, do_break;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_n;

  always_comb begin
    state_n  = state;
    do_make  = 1'b0;
    do_break = 1'b0;
    if (byte_strobe)
      case (state)
        S_IDLE:
          if (rx_byte == 8'hF0)      state_n = S_BREAK;
          else if (rx_byte == 8'hE0) state_n = S_EXT;
          else                       do_make = ~rx_byte[7];  // 0xAA, 0xFA, 0x83.. ignored
        S_BREAK: begin
          do_break = ~rx_byte[7];
          state_n  = S_IDLE;
        end
        S_EXT:   state_n = (rx_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: state_n = S_IDLE;  // extended keys never touch the outputs
      endcase
  end

  logic [127:0] key_down_q;
  logic [6:0]   last_change_q;
  logic         key_valid_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      key_valid_q <= do_make | do_break;
      if (do_make | do_break) begin
        key_down_q[rx_byte[6:0]] <= do_make;
        last_change_q            <= rx_byte[6:0];
      end
    end

  assign bus.key_down    = key_down_q;
  assign bus.last_change = last_change_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.frame_err   = rx_err;
endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;
  localparam int TO   = 200;
  localparam int SYNC = 2;
  localparam int HALF = 20;  // clk cycles per PS/2 half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_key_tracker_if bus();

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = key_valid, 2 = frame_err. cyc = -1 means the arrival cycle is not checked.
  typedef struct {
    int           kind;
    logic [6:0]   code;
    logic [127:0] kd;
    int           cyc;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  logic [127:0] exp_kd = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops an expectation whenever the DUT pulses an output.
  always @(negedge clk) begin
    if (!rst && (bus.key_valid || bus.frame_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {126'd0, bus.frame_err, bus.key_valid}, 128'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind", {126'd0, bus.frame_err, bus.key_valid}, (e.kind == 1) ? 128'd1 : 128'd2);
        chk("key_down", bus.key_down, e.kd);
        if (e.kind == 1) chk("last_change", {121'd0, bus.last_change}, {121'd0, e.code});
        if (e.cyc >= 0) chk("latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Sends the first nbits of a frame. On the stop edge it pushes the expected
  // event (kind 0 = none expected).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input int kind, input logic [6:0] code);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10 && kind != 0) begin
        exp_t e;
        e.kind = kind; e.code = code; e.kd = exp_kd;
        e.cyc  = cyc + SYNC + ((kind == 1) ? 2 : 1);
        q.push_back(e);
      end
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_key_down", bus.key_down, 128'd0);
    chk("rst_last_change", {121'd0, bus.last_change}, 128'd0);
    chk("rst_key_valid", {127'd0, bus.key_valid}, 128'd0);
    chk("rst_frame_err", {127'd0, bus.frame_err}, 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Make 0x1D, then break it; then break an already released key (0x12).
    exp_kd[29] = 1'b1;
    send_frame(8'h1D, 0, 11, 1, 7'h1D);
    send_frame(8'hF0, 0, 11, 0, 7'h00);
    exp_kd[29] = 1'b0;
    send_frame(8'h1D, 0, 11, 1, 7'h1D);
    send_frame(8'hF0, 0, 11, 0, 7'h00);
    send_frame(8'h12, 0, 11, 1, 7'h12);

    // Bad parity, then good 0x23.
    send_frame(8'h23, 1, 11, 2, 7'h00);
    exp_kd[35] = 1'b1;
    send_frame(8'h23, 0, 11, 1, 7'h23);

    // Extended sequences are silent; 0x83/0xAA ignored.
    send_frame(8'hE0, 0, 11, 0, 7'h00);
    send_frame(8'h75, 0, 11, 0, 7'h00);
    send_frame(8'hE0, 0, 11, 0, 7'h00);
    send_frame(8'hF0, 0, 11, 0, 7'h00);
    send_frame(8'h75, 0, 11, 0, 7'h00);
    exp_kd[28] = 1'b1;
    send_frame(8'h1C, 0, 11, 1, 7'h1C);
    send_frame(8'h83, 0, 11, 0, 7'h00);
    send_frame(8'hAA, 0, 11, 0, 7'h00);

    // Timeout mid-frame, then a clean 0x69.
    send_frame(8'h55, 0, 5, 0, 7'h00);
    begin
      exp_t e;
      e.kind = 2; e.code = 7'h00; e.kd = exp_kd; e.cyc = -1;
      q.push_back(e);
    end
    repeat (TO + 10) @(negedge clk);
    exp_kd[105] = 1'b1;
    send_frame(8'h69, 0, 11, 1, 7'h69);

    // Press 0x1D, repeat 0x1C (typematic), reset mid-frame, then 0x7A.
    exp_kd[29] = 1'b1;
    send_frame(8'h1D, 0, 11, 1, 7'h1D);
    send_frame(8'h1C, 0, 11, 1, 7'h1C);
    send_frame(8'h23, 0, 5, 0, 7'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    exp_kd = '0;
    exp_kd[122] = 1'b1;
    send_frame(8'h7A, 0, 11, 1, 7'h7A);

    repeat (20) @(negedge clk);
    chk("final_key_down", bus.key_down, exp_kd);
    chk("pending_events", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
